// File: rtl/keymap_latch.sv
// Keycode-to-player direction latch with conflict detection, idle timeout and
// optional per-player auto-repeat (enabled by defining KEYMAP_REPEAT_EN).
module keymap_latch #(
   parameter int unsigned NUM_SLOTS     = 2,
   parameter int unsigned NUM_PLAYERS   = 2,
   parameter logic [NUM_PLAYERS*32-1:0] KEY_TABLE =
      {8'h5C, 8'h5E, 8'h5D, 8'h60, 8'h04, 8'h07, 8'h16, 8'h1A},
   parameter int unsigned TIMEOUT       = 1_000_000,
   parameter int unsigned REPEAT_DELAY  = 250_000,
   parameter int unsigned REPEAT_PERIOD = 50_000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_SLOTS*8-1:0]   keycodes,
   input  logic                     key_valid,
   output logic [NUM_PLAYERS*8-1:0] player_key,
   output logic [NUM_PLAYERS*4-1:0] player_dir,
   output logic [NUM_PLAYERS-1:0]   player_press,
   output logic [NUM_PLAYERS-1:0]   player_conflict
);

   if (NUM_SLOTS < 1 || NUM_SLOTS > 6)         $error("NUM_SLOTS out of range");
   if (NUM_PLAYERS < 1 || NUM_PLAYERS > 4)     $error("NUM_PLAYERS out of range");
   if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)  $error("repeat timing must be >= 1");

   localparam int unsigned TW = $clog2(TIMEOUT) + 1;
   localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);
   localparam logic [TW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

   logic [TW-1:0]              timer_q;
   logic                       timeout_hit;
   logic [NUM_PLAYERS*4-1:0]   hit;
   logic [NUM_PLAYERS*8-1:0]   samp_key, nxt_key;
   logic [NUM_PLAYERS*4-1:0]   samp_dir, nxt_dir;
   logic [NUM_PLAYERS-1:0]     samp_conf, nxt_conf;
   logic [NUM_PLAYERS-1:0]     new_press, press_d;
   logic [3:0]                 m;

   function automatic logic [7:0] table_entry(input int unsigned p, input int unsigned d);
      return KEY_TABLE[(p*4+d)*8 +: 8];
   endfunction

   // Direction hits are ORed across slots, so duplicate slots count once.
   always_comb begin
      hit       = '0;
      samp_key  = '0;
      samp_dir  = '0;
      samp_conf = '0;
      m         = '0;
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
         for (int unsigned d = 0; d < 4; d++) begin
            for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
               if (keycodes[s*8 +: 8] != 8'h00 && keycodes[s*8 +: 8] == table_entry(p, d))
                  hit[p*4+d] = 1'b1;
            end
         end
         m = hit[p*4 +: 4];
         if (m != 4'd0 && (m & (m - 4'd1)) == 4'd0) begin
            samp_dir[p*4 +: 4] = m;
            for (int unsigned d = 0; d < 4; d++)
               if (m[d]) samp_key[p*8 +: 8] = table_entry(p, d);
         end else if (m != 4'd0) begin
            samp_conf[p] = 1'b1;
         end
      end
   end

   assign timeout_hit = (TIMEOUT != 0) && !key_valid && (timer_q == TO_LAST);

   always_comb begin
      nxt_key  = player_key;
      nxt_dir  = player_dir;
      nxt_conf = player_conflict;
      if (key_valid) begin
         nxt_key  = samp_key;
         nxt_dir  = samp_dir;
         nxt_conf = samp_conf;
      end else if (timeout_hit) begin
         nxt_key  = '0;
         nxt_dir  = '0;
         nxt_conf = '0;
      end
      new_press = '0;
      for (int unsigned p = 0; p < NUM_PLAYERS; p++)
         new_press[p] = (nxt_key[p*8 +: 8] != 8'h00) && (nxt_key[p*8 +: 8] != player_key[p*8 +: 8]);
   end

`ifdef KEYMAP_REPEAT_EN
   localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned CW   = $clog2(RMAX) + 1;

   typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} rpt_state_e;

   rpt_state_e    state_q [NUM_PLAYERS];
   rpt_state_e    state_d [NUM_PLAYERS];
   logic [CW-1:0] cnt_q   [NUM_PLAYERS];
   logic [CW-1:0] cnt_d   [NUM_PLAYERS];
   logic [NUM_PLAYERS-1:0] rep_pulse;

   // Hold time keeps counting between samples; only a key change or clear restarts it.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rep_pulse = '0;
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
         if (nxt_key[p*8 +: 8] == 8'h00) begin
            state_d[p] = S_IDLE;
            cnt_d[p]   = '0;
         end else if (nxt_key[p*8 +: 8] != player_key[p*8 +: 8]) begin
            state_d[p] = S_DELAY;
            cnt_d[p]   = '0;
         end else begin
            case (state_q[p])
               S_DELAY: begin
                  if (cnt_q[p] == CW'(REPEAT_DELAY - 1)) begin
                     state_d[p]   = S_REPEAT;
                     cnt_d[p]     = '0;
                     rep_pulse[p] = 1'b1;
                  end else begin
                     cnt_d[p] = cnt_q[p] + 1'b1;
                  end
               end
               S_REPEAT: begin
                  if (cnt_q[p] == CW'(REPEAT_PERIOD - 1)) begin
                     cnt_d[p]     = '0;
                     rep_pulse[p] = 1'b1;
                  end else begin
                     cnt_d[p] = cnt_q[p] + 1'b1;
                  end
               end
               default: begin
                  state_d[p] = S_DELAY;
                  cnt_d[p]   = '0;
               end
            endcase
         end
      end
      press_d = new_press | rep_pulse;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            state_q[p] <= S_IDLE;
            cnt_q[p]   <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
`else
   assign press_d = new_press;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_q         <= '0;
         player_key      <= '0;
         player_dir      <= '0;
         player_press    <= '0;
         player_conflict <= '0;
      end else begin
         if (key_valid)
            timer_q <= '0;
         else if (timer_q != TO_MAX)
            timer_q <= timer_q + 1'b1;
         player_key      <= nxt_key;
         player_dir      <= nxt_dir;
         player_press    <= press_d;
         player_conflict <= nxt_conf;
      end
   end

endmodule

// File: tb/tb_keymap_latch.sv
// Scoreboard bench for keymap_latch: stimulus pushes expected outputs tagged with
// the edge they apply to; a monitor pops and compares after each rising edge.
module tb_keymap_latch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] keycodes = '0;
   logic        key_valid = 1'b0;
   logic [15:0] player_key;
   logic [7:0]  player_dir;
   logic [1:0]  player_press;
   logic [1:0]  player_conflict;

   keymap_latch #(
      .NUM_SLOTS(2),
      .NUM_PLAYERS(2),
      .KEY_TABLE(64'h5C5E5D600407161A),
      .TIMEOUT(10),
      .REPEAT_DELAY(4),
      .REPEAT_PERIOD(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .keycodes(keycodes),
      .key_valid(key_valid),
      .player_key(player_key),
      .player_dir(player_dir),
      .player_press(player_press),
      .player_conflict(player_conflict)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         when;
      int         tag;
      logic [15:0] key;
      logic [7:0]  dir;
      logic [1:0]  press;
      logic [1:0]  conf;
      bit          cp;
   } exp_t;

   exp_t sb[$];
   int errors = 0;
   int checks = 0;
   int tag_n  = 0;

   task automatic step(input bit v, input logic [15:0] kc, input bit chk,
                       input logic [15:0] k, input logic [7:0] d,
                       input logic [1:0] pr, input logic [1:0] cf, input bit cp);
      exp_t e;
      @(negedge clk);
      key_valid = v;
      keycodes  = kc;
      if (chk) begin
         e.when  = cyc + 1;
         e.tag   = tag_n;
         e.key   = k;
         e.dir   = d;
         e.press = pr;
         e.conf  = cf;
         e.cp    = cp;
         sb.push_back(e);
      end
      tag_n++;
   endtask

   task automatic check_zero(input int tag);
      checks++;
      if (player_key !== 16'h0 || player_dir !== 8'h0 || player_press !== 2'b0 || player_conflict !== 2'b0) begin
         errors++;
         $display("FAIL async_reset[%0d]: key=%h dir=%h press=%b conf=%b, required all zero",
                  tag, player_key, player_dir, player_press, player_conflict);
      end
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         while (sb.size() > 0 && sb[0].when <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.when < cyc) begin
               errors++;
               $display("FAIL late[%0d]: expectation for edge %0d seen at %0d", e.tag, e.when, cyc);
            end else if (player_key !== e.key || player_dir !== e.dir || player_conflict !== e.conf ||
                         (e.cp && player_press !== e.press)) begin
               errors++;
               $display("FAIL step[%0d]: key=%h dir=%h press=%b conf=%b, required key=%h dir=%h press=%b conf=%b",
                        e.tag, player_key, player_dir, player_press, player_conflict,
                        e.key, e.dir, e.press, e.conf);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] rp;
      #1;
      check_zero(0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Basic mapping, hold, conflict, duplicate, direction change
      step(1, 16'h601A, 1, 16'h601A, 8'h11, 2'b11, 2'b00, 1);
      step(0, 16'h0000, 1, 16'h601A, 8'h11, 2'b00, 2'b00, 1);
      step(1, 16'h601A, 1, 16'h601A, 8'h11, 2'b00, 2'b00, 1);
      step(1, 16'h161A, 1, 16'h0000, 8'h00, 2'b00, 2'b01, 1);
      step(1, 16'h1A1A, 1, 16'h001A, 8'h01, 2'b01, 2'b00, 1);
      step(1, 16'h0007, 1, 16'h0007, 8'h04, 2'b01, 2'b00, 1);
      step(1, 16'h5C16, 1, 16'h5C16, 8'h82, 2'b11, 2'b00, 1);
      step(1, 16'h9912, 1, 16'h0000, 8'h00, 2'b00, 2'b00, 1);
      step(1, 16'h045E, 1, 16'h5E04, 8'h48, 2'b11, 2'b00, 1);
      step(1, 16'h5C5D, 1, 16'h0000, 8'h00, 2'b00, 2'b10, 1);

      // Idle timeout: clear exactly 10 edges after the latch edge
      step(1, 16'h0004, 1, 16'h0004, 8'h08, 2'b01, 2'b00, 1);
      for (int i = 1; i <= 9; i++)
         step(0, 16'h0000, 1, 16'h0004, 8'h08, 2'b00, 2'b00, 0);
      step(0, 16'h0000, 1, 16'h0000, 8'h00, 2'b00, 2'b00, 1);
      step(0, 16'h0000, 1, 16'h0000, 8'h00, 2'b00, 2'b00, 1);

      // key_valid on the expiry edge wins and restarts the timer
      step(1, 16'h001A, 1, 16'h001A, 8'h01, 2'b01, 2'b00, 1);
      for (int i = 1; i <= 9; i++)
         step(0, 16'h0000, i == 9, 16'h001A, 8'h01, 2'b00, 2'b00, 0);
      step(1, 16'h0016, 1, 16'h0016, 8'h02, 2'b01, 2'b00, 1);
      for (int i = 1; i <= 9; i++)
         step(0, 16'h0000, i == 9, 16'h0016, 8'h02, 2'b00, 2'b00, 0);
      step(0, 16'h0000, 1, 16'h0000, 8'h00, 2'b00, 2'b00, 1);

      // Held key with key_valid every cycle
      for (int i = 0; i <= 10; i++) begin
`ifdef KEYMAP_REPEAT_EN
         rp = (i == 0 || i == 4 || i == 7 || i == 10) ? 2'b01 : 2'b00;
`else
         rp = (i == 0) ? 2'b01 : 2'b00;
`endif
         step(1, 16'h0007, 1, 16'h0007, 8'h04, rp, 2'b00, 1);
      end

      // Asynchronous reset mid-hold, then a fresh press only on the next sample
      @(posedge clk);
      #3;
      rst       = 1'b1;
      key_valid = 1'b0;
      #1;
      check_zero(1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      step(0, 16'h0000, 1, 16'h0000, 8'h00, 2'b00, 2'b00, 1);
      step(1, 16'h0007, 1, 16'h0007, 8'h04, 2'b01, 2'b00, 1);
      step(0, 16'h0000, 1, 16'h0007, 8'h04, 2'b00, 2'b00, 1);
      step(0, 16'h0000, 1, 16'h0007, 8'h04, 2'b00, 2'b00, 1);

      for (int i = 0; i < 20 && sb.size() > 0; i++)
         @(negedge clk);
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations never reached, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/keymap_latch.md
KEYMAP_LATCH -- requirements
Module: keymap_latch

Interface
REQ-001 Parameter NUM_SLOTS, default 2: keycodes delivered per NIOS sample, range 1..6.
REQ-002 Parameter NUM_PLAYERS, default 2: player channels, range 1..4.
REQ-003 Parameter KEY_TABLE, default {8'h5C,8'h5E,8'h5D,8'h60,8'h04,8'h07,8'h16,8'h1A}: NUM_PLAYERS*32 bits; player p, direction d at bits [(p*4+d)*8 +: 8]; d 0=up, 1=down, 2=right, 3=left.
REQ-004 Parameter TIMEOUT, default 1_000_000: idle cycles without key_valid before the latch is cleared; 0 disables the timeout.
REQ-005 Parameter REPEAT_DELAY, default 250_000: hold cycles before the first auto-repeat pulse.
REQ-006 Parameter REPEAT_PERIOD, default 50_000: cycles between subsequent auto-repeat pulses.
REQ-007 Clk  input  1  system clock; all state updates on the rising edge.
REQ-008 Reset  input  1  asynchronous, active-high reset.
REQ-009 keycodes  input  NUM_SLOTS*8  slot i at [i*8 +: 8]; 8'h00 = empty slot.
REQ-010 key_valid  input  1  one-cycle strobe; keycodes are valid when high.
REQ-011 player_key  output  NUM_PLAYERS*8  latched keycode per player; 8'h00 = none.
REQ-012 player_dir  output  NUM_PLAYERS*4  one-hot direction per player, bit order matches d.
REQ-013 player_press  output  NUM_PLAYERS  one-cycle pulse on a new press or an auto-repeat.
REQ-014 player_conflict  output  NUM_PLAYERS  high while a player holds two or more distinct own keys.

Function
REQ-015 Matching: a slot matches (p,d) when the slot is nonzero and equals the KEY_TABLE entry; unmatched codes are ignored.
REQ-016 Duplicates: identical keycodes in several slots count as one key.
REQ-017 Exactly one distinct matched key for player p: player_key = that code, player_dir = one-hot d, conflict = 0.
REQ-018 Two or more distinct matched keys for player p: player_key = 0, player_dir = 0, conflict = 1; other players are unaffected.
REQ-019 Zero matched keys for player p: player_key = 0, player_dir = 0, conflict = 0.
REQ-020 Latency: outputs update on the edge where key_valid = 1 and hold until the next key_valid, timeout or reset.
REQ-021 Press: player_press[p] pulses on the same edge player_key[p] changes to a nonzero value, including a direct change from one direction to another.
REQ-022 Idle timer: counts cycles since the last key_valid, saturating; at count = TIMEOUT all players clear to zero with no press pulse, and the timer restarts on the next key_valid.
REQ-023 Simultaneous key_valid and timeout expiry: key_valid wins; the new sample is latched and the timer clears.
REQ-024 Per-player repeat FSM states: IDLE (key = 0), DELAY, REPEAT.
REQ-025 Repeat transitions: a new nonzero key goes to DELAY with the counter cleared; the key clearing returns to IDLE; a changed key re-enters DELAY.
REQ-026 DELAY -> REPEAT when the counter reaches REPEAT_DELAY-1, emitting one press pulse.
REQ-027 In REPEAT, one press pulse is emitted every REPEAT_PERIOD cycles while the key is unchanged.
REQ-028 Counter widths are $clog2 of the respective parameter plus 1; counters never wrap.

Reset
REQ-029 Reset asserted: player_key = 0, player_dir = 0, player_press = 0, player_conflict = 0, all FSMs IDLE, all counters 0, effective immediately without a clock edge.
REQ-030 Reset mid-hold or mid-repeat discards state; after release, a still-held key produces a fresh press only on the next key_valid.

Configuration
REQ-031 Macro KEYMAP_REPEAT_EN defined: the repeat FSM and counters (REQ-024..REQ-028) are present.
REQ-032 KEYMAP_REPEAT_EN undefined: no repeat logic; player_press pulses only per REQ-021; REPEAT_DELAY and REPEAT_PERIOD are unused.

Verification
REQ-033 keycodes = {8'h60,8'h1A}, key_valid pulse -> next cycle: player_key = {8'h60,8'h1A}, player_dir = {4'b0001,4'b0001}, press = 2'b11.
REQ-034 keycodes = {8'h16,8'h1A} -> P0 conflict = 1, key = 0; P1 key = 0, conflict = 0; press = 2'b00.
REQ-035 keycodes = {8'h1A,8'h1A} -> P0 key = 8'h1A, conflict = 0 (duplicate slots).
REQ-036 TIMEOUT = 10, single key_valid with 8'h04, then idle -> outputs zero exactly 10 cycles after the latch edge, no press pulse.
REQ-037 KEYMAP_REPEAT_EN defined, REPEAT_DELAY = 4, REPEAT_PERIOD = 3, 8'h07 held with key_valid every cycle -> P0 press at t0, t0+4, t0+7, t0+10.
REQ-038 Reset asserted mid-REPEAT -> all outputs 0 asynchronously; after release, the first key_valid with 8'h07 -> a single press pulse.
